// File: rtl/dpram_pkg.sv
// Shared types and helpers for the byte-enable dual-port RAM and its clear controller.
package dpram_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } dpram_state_e;

   // Same-address read-during-write selection.
   localparam int RDW_OLD = 0;
   localparam int RDW_NEW = 1;

   // Widest word the merge helper handles; callers zero-extend narrower words.
   localparam int MERGE_MAX_W = 512;
   localparam int MERGE_MAX_B = MERGE_MAX_W / 8;

   // Byte-lane merge: lanes with be set take new_word, the rest keep old_word.
   function automatic logic [MERGE_MAX_W-1:0] byte_merge(
      input logic [MERGE_MAX_W-1:0] old_word,
      input logic [MERGE_MAX_W-1:0] new_word,
      input logic [MERGE_MAX_B-1:0] be
   );
      logic [MERGE_MAX_W-1:0] res;
      res = old_word;
      for (int i = 0; i < MERGE_MAX_B; i++) begin
         if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/dpram_clear_ctrl.sv
// Clear sequencer: owns CLEAR/READY state, the clear address counter and the
// array write-port mux (clear writes during CLEAR, user writes once READY).
module dpram_clear_ctrl
   import dpram_pkg::*;
#(
   parameter int DEPTH      = 16,
   parameter int WIDTH      = 8,
   parameter int CLR_ON_RST = 1,
   parameter int AW         = $clog2(DEPTH),
   parameter int NB         = WIDTH / 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wenc,
   input  logic [AW-1:0]   waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [NB-1:0]   wbe,
   output logic            ready,
   output logic            init_busy,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   output logic [NB-1:0]   mem_wbe
);

   localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

   dpram_state_e    state_q, state_d;
   logic [AW-1:0]   cnt_q, cnt_d;

   // State and clear counter; reset restarts the sweep from word 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= (CLR_ON_RST != 0) ? CLEAR : READY;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state and write-port mux; nothing reaches the array while rst is high.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mem_we    = 1'b0;
      mem_addr  = waddr;
      mem_wdata = wdata;
      mem_wbe   = wbe;
      case (state_q)
         CLEAR: begin
            mem_we    = ~rst;
            mem_addr  = cnt_q;
            mem_wdata = '0;
            mem_wbe   = '1;
            if (cnt_q == LAST) state_d = READY;
            else               cnt_d   = cnt_q + AW'(1);
         end
         READY: begin
            mem_we = ~rst & wenc & ({1'b0, waddr} < DEPTH_L);
         end
      endcase
   end

   assign ready     = ~rst & (state_q == READY);
   assign init_busy = rst ? (CLR_ON_RST != 0) : (state_q == CLEAR);

endmodule

// File: rtl/dual_port_ram_be.sv
// Single-clock simple dual-port RAM with byte-lane writes, 1- or 2-cycle
// registered reads, selectable read-during-write and a post-reset clear sweep.
module dual_port_ram_be
   import dpram_pkg::*;
#(
   parameter int DEPTH      = 16,
   parameter int WIDTH      = 8,
   parameter int RD_LAT     = 1,
   parameter int RDW_MODE   = 0,
   parameter int CLR_ON_RST = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wenc,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [WIDTH/8-1:0]       wbe,
   input  logic                     renc,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata,
   output logic                     rvalid,
   output logic                     init_busy
);

   localparam int          AW      = $clog2(DEPTH);
   localparam int          NB      = WIDTH / 8;
   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

   if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
      $error("dual_port_ram_be: RD_LAT must be 1 or 2");
   end
   if (WIDTH % 8 != 0 || WIDTH < 8 || WIDTH > MERGE_MAX_W) begin : g_bad_width
      $error("dual_port_ram_be: WIDTH must be a non-zero multiple of 8 within the merge limit");
   end
   if (DEPTH < 2) begin : g_bad_depth
      $error("dual_port_ram_be: DEPTH must be at least 2");
   end

   function automatic logic [WIDTH-1:0] merge_word(
      input logic [WIDTH-1:0] old_word,
      input logic [WIDTH-1:0] new_word,
      input logic [NB-1:0]    be
   );
      logic [MERGE_MAX_W-1:0] wide;
      wide = byte_merge(MERGE_MAX_W'(old_word), MERGE_MAX_W'(new_word), MERGE_MAX_B'(be));
      return wide[WIDTH-1:0];
   endfunction

   logic [WIDTH-1:0] mem [DEPTH];

   logic             ready;
   logic             mem_we;
   logic [AW-1:0]    mem_addr;
   logic [WIDTH-1:0] mem_wdata;
   logic [NB-1:0]    mem_wbe;

   dpram_clear_ctrl #(
      .DEPTH      (DEPTH),
      .WIDTH      (WIDTH),
      .CLR_ON_RST (CLR_ON_RST),
      .AW         (AW),
      .NB         (NB)
   ) u_clear_ctrl (
      .clk       (clk),
      .rst       (rst),
      .wenc      (wenc),
      .waddr     (waddr),
      .wdata     (wdata),
      .wbe       (wbe),
      .ready     (ready),
      .init_busy (init_busy),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wbe   (mem_wbe)
   );

   // Array write: lane-merged update of the addressed word.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= merge_word(mem[mem_addr], mem_wdata, mem_wbe);
   end

   logic             rd_ok;
   logic [WIDTH-1:0] rd_word;
   logic             vld_out;
   logic [WIDTH-1:0] data_out;

   assign rd_ok = ready & renc;

   // Array read with optional same-address bypass of the byte-merged write.
   always_comb begin
      rd_word = '0;
      if ({1'b0, raddr} < DEPTH_L) begin
         rd_word = mem[raddr];
         if (RDW_MODE == RDW_NEW && mem_we && mem_addr == raddr)
            rd_word = merge_word(rd_word, mem_wdata, mem_wbe);
      end
   end

   // ---- stage p1: array sampled on the accepting edge (two-cycle reads only) ----
   if (RD_LAT == 2) begin : g_lat2
      logic             vld_p1;
      logic [WIDTH-1:0] data_p1;

      // Hold the sampled word so later writes cannot disturb the in-flight read.
      always_ff @(posedge clk) begin
         if (rst) vld_p1 <= 1'b0;
         else     vld_p1 <= rd_ok;
         if (rd_ok) data_p1 <= rd_word;
      end

      assign vld_out  = vld_p1;
      assign data_out = data_p1;
   end else begin : g_lat1
      assign vld_out  = rd_ok;
      assign data_out = rd_word;
   end

   // ---- output stage: registered rdata holds until the next completed read ----
   always_ff @(posedge clk) begin
      if (rst) begin
         rvalid <= 1'b0;
         rdata  <= '0;
      end else begin
         rvalid <= vld_out;
         if (vld_out) rdata <= data_out;
      end
   end

endmodule

// File: doc/dual_port_ram_be.md
Name: dual_port_ram_be

Overview:
Single-clock simple dual-port RAM (one write port, one read port). It is the parametrised successor of the team's basic dual-port RAM and adds:
- byte-lane write enables
- selectable read latency (1 or 2)
- selectable read-during-write behaviour
- a reset-triggered clear sequencer that zeroes every word before the RAM accepts traffic
Used as the storage core under sync FIFOs and line buffers.

Parameters:
DEPTH, 16, number of words; any value >= 2, not required to be a power of two
WIDTH, 8, word width in bits; must be a multiple of 8
RD_LAT, 1, read latency in cycles; legal values 1 or 2
RDW_MODE, 0, same-address read-during-write: 0 = old data, 1 = new data (byte-merged)
CLR_ON_RST, 1, 1 = zero all words after reset; 0 = skip the clear sequence

Ports:
clk  input  1  single clock; all logic on its rising edge
rst  input  1  synchronous active-high reset
wenc  input  1  write enable
waddr  input  $clog2(DEPTH)  write address
wdata  input  WIDTH  write data
wbe  input  WIDTH/8  byte enables; bit i gates wdata[8i+7:8i]
renc  input  1  read enable
raddr  input  $clog2(DEPTH)  read address
rdata  output  WIDTH  read data, registered
rvalid  output  1  one-cycle pulse marking new rdata
init_busy  output  1  high while the clear sequence runs

Behaviour:
Reset:
- While rst is high: rdata=0, rvalid=0, read pipeline flushed, clear counter=0.
- State goes to CLEAR if CLR_ON_RST=1, otherwise to READY.
- init_busy=1 during reset when CLR_ON_RST=1, else 0.
- Memory contents are not reset directly.

State machine (CLEAR, READY):
- CLEAR: each cycle writes 0 to mem[cnt] across all lanes, then cnt++.
- After writing cnt=DEPTH-1, go to READY. CLEAR lasts exactly DEPTH cycles after rst falls.
- In CLEAR: init_busy=1; wenc and renc are ignored (dropped, not queued); rvalid stays 0.
- READY: init_busy=0. Stays in READY until rst.
- Reset mid-CLEAR or mid-read restarts CLEAR from address 0 and discards any in-flight read.

Write (READY only):
- When wenc=1 and waddr<DEPTH, each lane i with wbe[i]=1 is updated; other lanes keep their value.
- wbe all zero: no change.
- waddr>=DEPTH: write dropped.

Read (READY only):
- renc=1 at edge t: rdata updates and rvalid=1 at edge t+RD_LAT.
- rdata holds its value when no read completes.
- Back-to-back reads are accepted every cycle; throughput is 1 per cycle.
- raddr>=DEPTH: rdata=0, rvalid still pulses.
- RD_LAT=2: the array is sampled at stage 1. A write on the following cycle does not alter the in-flight data.

Same-cycle wenc and renc to the same address:
- RDW_MODE=0: returns the pre-write word.
- RDW_MODE=1: returns the merged word (wdata in enabled lanes, old data elsewhere).
- Different addresses: fully independent.

Elaboration check: RD_LAT outside {1,2} or WIDTH%8!=0 is an error.

Decomposition:
- Shared package dpram_pkg holds:
  - state enum {CLEAR, READY}
  - RDW_OLD=0 and RDW_NEW=1 constants
  - function computing the byte-merged word from old, new and wbe (used by both the write path and the RDW_NEW bypass)
- One sub-module, dpram_clear_ctrl, owns the state register, clear counter, init_busy, and the write-mux select between clear writes and user writes.

Test Plan:
- Clear: DEPTH=16, CLR_ON_RST=1. Release rst, then drive wenc/renc during the first 16 cycles -> init_busy high exactly 16 cycles, rvalid stays 0, and reads of addr 0..15 afterwards all return 0x00.
- Byte enables: WIDTH=32. Write 0xAABBCCDD to addr 3 with wbe=4'hF, then 0x11223344 with wbe=4'b0101; read addr 3 -> 0xAA22CC44.
- Latency: RD_LAT=2. Write mem[5]=0x5A, read addr 5 at edge t, write mem[5]=0xFF at t+1 -> rvalid and rdata=0x5A at t+2.
- Read-during-write: same-cycle write 0x77 and read of addr 7 (old value 0x10) -> RDW_MODE=0 returns 0x10; RDW_MODE=1 returns 0x77.
- Reset mid-operation: assert rst for one cycle with a read in flight -> rvalid never pulses for that read, rdata=0, and CLEAR restarts (init_busy high for DEPTH cycles).
- Non-power-of-2: DEPTH=12. Write to addr 13 -> dropped (addr 1 unchanged); read addr 13 -> rdata=0 with rvalid pulse.
